// File: rtl/dbus_responder.sv
// Data-bus responder: accepts one request at a time and answers it after a fixed
// number of cycles, serving reads and byte-lane writes from a 64-bit wide SRAM.
package dbus_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_responder #(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  dbus_pkg::dbus_req_t  dreq,
    output dbus_pkg::dbus_resp_t dresp,
    output logic                 oor_err
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3'd3;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic            w_accept;
    logic            w_to_resp;

    logic [63:0]     w_off;
    logic            w_inr_new;
    logic [AW-1:0]   w_idx_new;
    logic [AW-1:0]   w_rd_idx;
    logic            w_rd_inr;
    logic            w_wr_en;
    logic            w_unused;

    logic [AW-1:0]   r_idx;
    logic            r_inr;
    logic [7:0]      r_strobe;
    logic [63:0]     r_wdata;
    logic [63:0]     r_mem [DEPTH];

    logic            r_addr_ok;
    logic            r_data_ok;
    logic [63:0]     r_rdata;
    logic            r_oor;

    // Address decode of the live request; the low three bits only select lanes.
    assign w_off     = dreq.addr - BASE;
    assign w_inr_new = (dreq.addr >= BASE) && (w_off < SPAN);
    assign w_idx_new = w_off[AW+2:3];
    assign w_unused  = ^{dreq.size, w_off[2:0]};

    // With LATENCY==1 the array is read on the accepting edge, before anything is latched.
    assign w_rd_idx = (r_state == S_IDLE) ? w_idx_new : r_idx;
    assign w_rd_inr = (r_state == S_IDLE) ? w_inr_new : r_inr;
    assign w_wr_en  = (r_state == S_RESP) && r_inr && (r_strobe != 8'd0);

    // Next-state and counter logic for the request/wait/response sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_to_resp   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dreq.valid) begin
                    w_accept = 1'b1;
                    if (CNT_INIT == 4'd0) begin
                        w_state_nxt = S_RESP;
                        w_to_resp   = 1'b1;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!dreq.valid) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_to_resp   = 1'b1;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, latched request and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= {AW{1'b0}};
            r_inr     <= 1'b0;
            r_strobe  <= 8'd0;
            r_wdata   <= 64'd0;
            r_addr_ok <= 1'b0;
            r_data_ok <= 1'b0;
            r_rdata   <= 64'd0;
            r_oor     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx    <= w_idx_new;
                r_inr    <= w_inr_new;
                r_strobe <= dreq.strobe;
                r_wdata  <= dreq.data;
            end
            r_addr_ok <= w_to_resp;
            r_data_ok <= w_to_resp;
            r_oor     <= w_to_resp & ~w_rd_inr;
            r_rdata   <= (w_to_resp && w_rd_inr) ? r_mem[w_rd_idx] : 64'd0;
        end
    end

    // Byte-lane write on the edge leaving RESP; a reset during RESP suppresses it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (r_strobe[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dresp.addr_ok = r_addr_ok;
    assign dresp.data_ok = r_data_ok;
    assign dresp.data    = r_rdata;
    assign oor_err       = r_oor;
endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: four latency builds share one clock, a
// transaction-level model predicts every response cycle, data word and error pulse.
module tb_dbus_responder;
    import dbus_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  req [4];
    dbus_resp_t rsp [4];
    logic       oor [4];

    int lat_of [4] = '{2, 1, 5, 3};
    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    logic [63:0] mdl [longint];
    int          p_due [4];
    bit          p_inr [4];
    longint      p_key [4];
    logic [7:0]  p_strb [4];
    logic [63:0] p_wd [4];
    bit          cm_v [4];
    longint      cm_key [4];
    logic [7:0]  cm_strb [4];
    logic [63:0] cm_wd [4];

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) u_l2 (
        .clk(clk), .reset(reset), .dreq(req[0]), .dresp(rsp[0]), .oor_err(oor[0]));
    dbus_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u_l1 (
        .clk(clk), .reset(reset), .dreq(req[1]), .dresp(rsp[1]), .oor_err(oor[1]));
    dbus_responder #(.DEPTH(DEPTH), .LATENCY(5), .BASE(BASE)) u_l5 (
        .clk(clk), .reset(reset), .dreq(req[2]), .dresp(rsp[2]), .oor_err(oor[2]));
    dbus_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE(BASE)) u_l3 (
        .clk(clk), .reset(reset), .dreq(req[3]), .dresp(rsp[3]), .oor_err(oor[3]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < LIMIT);
    endfunction

    function automatic longint key_of(input int inst, input logic [63:0] a);
        logic [63:0] idx;
        idx = ((a - BASE) >> 3) % 64'(DEPTH);
        return (longint'(inst) << 20) | longint'(idx);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model; writes land in the model one cycle after the response.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < 4; i++) begin
                    logic [63:0] w;
                    bit          known;
                    bit          due;
                    if (cm_v[i]) begin
                        cm_v[i] = 1'b0;
                        known = mdl.exists(cm_key[i]) || (cm_strb[i] == 8'hFF);
                        w = mdl.exists(cm_key[i]) ? mdl[cm_key[i]] : 64'd0;
                        for (int b = 0; b < 8; b++)
                            if (cm_strb[i][b]) w[8*b +: 8] = cm_wd[i][8*b +: 8];
                        if (known) mdl[cm_key[i]] = w;
                    end
                    due = (p_due[i] == cyc);
                    chk("data_ok", i, 64'(rsp[i].data_ok), 64'(due));
                    chk("addr_ok", i, 64'(rsp[i].addr_ok), 64'(due));
                    chk("oor_err", i, 64'(oor[i]), 64'(due && !p_inr[i]));
                    if (due) begin
                        if (!p_inr[i]) chk("rdata_oor", i, rsp[i].data, 64'd0);
                        else if (mdl.exists(p_key[i])) chk("rdata", i, rsp[i].data, mdl[p_key[i]]);
                        if (p_inr[i] && (p_strb[i] != 8'd0)) begin
                            cm_v[i]    = 1'b1;
                            cm_key[i]  = p_key[i];
                            cm_strb[i] = p_strb[i];
                            cm_wd[i]   = p_wd[i];
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int inst, input logic [63:0] addr, input logic [7:0] strb,
                         input logic [63:0] wd, input bit scr,
                         output logic [63:0] rd, output int lat, output int rc, output logic ooe);
        @(negedge clk);
        req[inst].valid  = 1'b1;
        req[inst].addr   = addr;
        req[inst].size   = MSIZE8;
        req[inst].strobe = strb;
        req[inst].data   = wd;
        p_due[inst]  = cyc + lat_of[inst];
        p_inr[inst]  = in_range(addr);
        p_key[inst]  = key_of(inst, addr);
        p_strb[inst] = strb;
        p_wd[inst]   = wd;
        lat = 0; rd = 64'd0; rc = -1; ooe = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp[inst].data_ok) begin
                lat = k; rd = rsp[inst].data; rc = cyc; ooe = oor[inst];
                break;
            end
            if (scr && k == 1) begin
                req[inst].addr = req[inst].addr ^ 64'h40;
                req[inst].data = ~req[inst].data;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL timeout inst=%0d addr=%h", inst, addr);
        end
    endtask

    task automatic release_req(input int inst);
        @(negedge clk);
        req[inst].valid  = 1'b0;
        req[inst].strobe = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        int          lat;
        int          rc;
        int          rc2;
        logic        ooe;

        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req[i] = '0;
            p_due[i] = -100;
            cm_v[i] = 1'b0;
        end
        #1 reset = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_ok", 0, 64'(rsp[0].data_ok), 64'd0);
        chk("rst_data", 0, rsp[0].data, 64'd0);
        chk("rst_oor", 0, 64'(oor[0]), 64'd0);
        reset = 1'b1;

        // LATENCY=2: full write, read back, byte and sparse-strobe merges.
        issue(0, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0, rd, lat, rc, ooe);
        chk("wr_lat", 0, 64'(lat), 64'd2);
        issue(0, 64'h8000_0010, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("rd_lat", 0, 64'(lat), 64'd2);
        chk("rd_full", 0, rd, 64'h1122334455667788);
        chk("rd_oor_pin", 0, 64'(ooe), 64'd0);
        issue(0, 64'h8000_0013, 8'h08, 64'h00000000AA000000, 1'b0, rd, lat, rc, ooe);
        issue(0, 64'h8000_0010, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("rd_byte", 0, rd, 64'h11223344AA667788);
        issue(0, 64'h8000_0018, 8'hFF, 64'h0123456789ABCDEF, 1'b0, rd, lat, rc, ooe);
        issue(0, 64'h8000_0018, 8'hA5, 64'hFFFFFFFFFFFFFFFF, 1'b0, rd, lat, rc, ooe);
        chk("wr_pre_data", 0, rd, 64'h0123456789ABCDEF);
        issue(0, 64'h8000_0018, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("rd_sparse", 0, rd, 64'hFF23FF6789FFCDFF);

        // Out-of-range accesses on both sides of the window leave the array alone.
        issue(0, 64'h8000_0000, 8'hFF, 64'hA0A0A0A0A0A0A0A0, 1'b0, rd, lat, rc, ooe);
        issue(0, 64'h8000_7FF8, 8'hFF, 64'hB0B0B0B0B0B0B0B0, 1'b0, rd, lat, rc, ooe);
        issue(0, 64'h7FFF_FFF8, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("oor_lo_lat", 0, 64'(lat), 64'd2);
        chk("oor_lo_pin", 0, 64'(ooe), 64'd1);
        chk("oor_lo_data", 0, rd, 64'd0);
        issue(0, 64'h7FFF_FFF8, 8'hFF, 64'hDEADDEADDEADDEAD, 1'b0, rd, lat, rc, ooe);
        issue(0, 64'h8000_8000, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("oor_hi_pin", 0, 64'(ooe), 64'd1);
        issue(0, 64'h8000_8000, 8'hFF, 64'hBEEFBEEFBEEFBEEF, 1'b0, rd, lat, rc, ooe);
        issue(0, 64'h8000_0000, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("oor_keep0", 0, rd, 64'hA0A0A0A0A0A0A0A0);
        issue(0, 64'h8000_7FF8, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("oor_keepN", 0, rd, 64'hB0B0B0B0B0B0B0B0);

        // Reset during the RESP cycle of a write drops it.
        issue(0, 64'h8000_0010, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0, rd, lat, rc, ooe);
        #1;
        reset = 1'b0;
        req[0] = '0;
        cm_v[0] = 1'b0;
        #1;
        chk("rsp_rst_ok", 0, 64'(rsp[0].data_ok), 64'd0);
        chk("rsp_rst_aok", 0, 64'(rsp[0].addr_ok), 64'd0);
        chk("rsp_rst_data", 0, rsp[0].data, 64'd0);
        chk("rsp_rst_oor", 0, 64'(oor[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(0, 64'h8000_0010, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("rsp_rst_keep", 0, rd, 64'h11223344AA667788);
        chk("rsp_rst_lat", 0, 64'(lat), 64'd2);
        release_req(0);

        // LATENCY=1: back-to-back reads held valid.
        issue(1, 64'h8000_0100, 8'hFF, 64'h0F0E0D0C0B0A0908, 1'b0, rd, lat, rc, ooe);
        issue(1, 64'h8000_0100, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("l1_lat", 1, 64'(lat), 64'd1);
        chk("l1_data", 1, rd, 64'h0F0E0D0C0B0A0908);
        issue(1, 64'h8000_0100, 8'h00, 64'd0, 1'b0, rd, lat, rc2, ooe);
        chk("l1_space", 1, 64'(rc2 - rc), 64'd2);
        release_req(1);

        // LATENCY=5: fields scrambled while waiting must be ignored.
        issue(2, 64'h8000_0200, 8'hFF, 64'h5A5A5A5A12345678, 1'b1, rd, lat, rc, ooe);
        issue(2, 64'h8000_0200, 8'h00, 64'd0, 1'b1, rd, lat, rc, ooe);
        chk("l5_lat", 2, 64'(lat), 64'd5);
        chk("l5_data", 2, rd, 64'h5A5A5A5A12345678);
        issue(2, 64'h8000_0200, 8'h00, 64'd0, 1'b0, rd, lat, rc2, ooe);
        chk("l5_space", 2, 64'(rc2 - rc), 64'd6);
        release_req(2);

        // LATENCY=3: write aborted one cycle into WAIT never lands.
        issue(3, 64'h8000_0300, 8'hFF, 64'hCAFEF00D12345678, 1'b0, rd, lat, rc, ooe);
        release_req(3);
        @(negedge clk);
        req[3].valid  = 1'b1;
        req[3].addr   = 64'h8000_0300;
        req[3].size   = MSIZE8;
        req[3].strobe = 8'hFF;
        req[3].data   = 64'h1111111111111111;
        @(negedge clk);
        req[3].valid  = 1'b0;
        req[3].strobe = 8'd0;
        repeat (5) @(negedge clk);
        issue(3, 64'h8000_0300, 8'h00, 64'd0, 1'b0, rd, lat, rc, ooe);
        chk("l3_abort_keep", 3, rd, 64'hCAFEF00D12345678);
        chk("l3_lat", 3, 64'(lat), 64'd3);
        release_req(3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
